// File: rtl/pipe_pkg.sv
// Shared types for the elastic inter-stage registers: the stage occupancy enum
// and the packed payload carried by each stage boundary.
package pipe_pkg;

    // Bit 0 flags a valid main entry and bit 1 a valid skid entry, so both
    // valid bits come straight off the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
    } id_ex_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_data;
        logic [4:0]      rd;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer that registers in_ready.
//
// Handshake: a payload moves on a side when valid and ready are both high at
// the rising edge; valid never depends on ready, and a held payload stays
// stable until it is taken.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count
);

    logic             in_fire;
    logic             out_fire;
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_data_q;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};

    generate
        if (SKID) begin : g_skid
            stage_state_e     state_q;
            stage_state_e     state_d;
            logic [WIDTH-1:0] skid_data_q;
            logic [WIDTH-1:0] skid_data_d;

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                skid_data_d = skid_data_q;
                if (flush) begin
                    state_d = EMPTY;
                    if (CLEAR_ON_FLUSH) begin
                        main_data_d = '0;
                        skid_data_d = '0;
                    end
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d     = ONE;
                                main_data_d = in_data;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_data_d = in_data;
                            end else if (in_fire) begin
                                state_d     = FULL;
                                skid_data_d = in_data;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            // in_ready is low here, so only the skid->main move can happen.
                            if (out_fire) begin
                                state_d     = ONE;
                                main_data_d = skid_data_q;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge CLK or posedge rst) begin
                if (rst) begin
                    state_q     <= EMPTY;
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q     <= state_d;
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end
            end

            assign main_v   = state_q[0];
            assign skid_v   = state_q[1];
            assign in_ready = ~state_q[1];
        end else begin : g_single
            logic main_v_q;
            logic main_v_d;

            always_comb begin
                main_v_d    = main_v_q;
                main_data_d = main_data_q;
                if (flush) begin
                    main_v_d = 1'b0;
                    if (CLEAR_ON_FLUSH) begin
                        main_data_d = '0;
                    end
                end else if (in_fire) begin
                    main_v_d    = 1'b1;
                    main_data_d = in_data;
                end else if (out_fire) begin
                    main_v_d = 1'b0;
                end
            end

            always_ff @(posedge CLK or posedge rst) begin
                if (rst) begin
                    main_v_q    <= 1'b0;
                    main_data_q <= '0;
                end else begin
                    main_v_q    <= main_v_d;
                    main_data_q <= main_data_d;
                end
            end

            assign main_v = main_v_q;
            assign skid_v = 1'b0;
            // Combinational out_ready -> in_ready path: the entry can be replaced
            // in the same cycle it leaves.
            assign in_ready = ~main_v_q | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance (clear on flush) and a
// single-entry instance (data kept on flush), directed vectors plus a random run.
module tb_pipe_stage_elastic;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    logic         in_valid0 = 1'b0, out_ready0 = 1'b0, flush0 = 1'b0;
    logic [W-1:0] in_data0 = '0;
    logic         in_ready0, out_valid0;
    logic [W-1:0] out_data0;
    logic [1:0]   count0;

    int n_checks = 0;
    int n_errors = 0;
    bit sb_en    = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp0_q[$];

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.WIDTH(W), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut (
        .CLK(CLK), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .count(count)
    );

    pipe_stage_elastic #(.WIDTH(W), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b0)) dut0 (
        .CLK(CLK), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .flush(flush0), .count(count0)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboards: sample at the falling edge, i.e. the values the next rising edge will see.
    always @(negedge CLK) begin
        if (sb_en && !rst) begin
            check("sb_count", {30'd0, count}, exp_q.size());
            if (out_valid) begin
                check("sb_has_entry", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) check("sb_data", out_data, exp_q[0]);
            end
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    always @(negedge CLK) begin
        if (sb_en && !rst) begin
            check("sb0_count", {30'd0, count0}, exp0_q.size());
            if (out_valid0) begin
                check("sb0_has_entry", {31'd0, exp0_q.size() != 0}, 1);
                if (exp0_q.size() != 0) check("sb0_data", out_data0, exp0_q[0]);
            end
            if (out_valid0 && out_ready0 && exp0_q.size() != 0) void'(exp0_q.pop_front());
            if (flush0) exp0_q.delete();
            else if (in_valid0 && in_ready0) exp0_q.push_back(in_data0);
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", {30'd0, count}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst0_in_ready", {31'd0, in_ready0}, 1);
        step();
        rst = 1'b0;

        // First transfer, 1-cycle latency
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_out_valid", {31'd0, out_valid}, 1);
        check("lat_out_data", out_data, 32'hDEADBEEF);
        check("lat_count", {30'd0, count}, 1);
        check("lat_in_ready", {31'd0, in_ready}, 1);
        step();
        check("lat_drain_count", {30'd0, count}, 0);

        // Skid fill with a stalled consumer, then ordered drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        step();
        check("skid_one_in_ready", {31'd0, in_ready}, 1);
        in_data = 32'h2;
        step();
        check("skid_full_count", {30'd0, count}, 2);
        check("skid_full_in_ready", {31'd0, in_ready}, 0);
        check("skid_full_data", out_data, 32'h1);
        in_data = 32'h3;
        step();
        check("skid_hold_count", {30'd0, count}, 2);
        check("skid_hold_data", out_data, 32'h1);
        out_ready = 1'b1;
        step();
        check("drain_2", out_data, 32'h2);
        check("drain_2_count", {30'd0, count}, 1);
        check("drain_2_in_ready", {31'd0, in_ready}, 1);
        step();
        in_valid = 1'b0;
        check("drain_3", out_data, 32'h3);
        check("drain_3_count", {30'd0, count}, 1);
        step();
        check("drain_empty", {31'd0, out_valid}, 0);

        // Flush while full, with a payload offered in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        check("pre_flush_count", {30'd0, count}, 2);
        flush = 1'b1; in_data = 32'hAA;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 0);
        check("flush_count", {30'd0, count}, 0);
        check("flush_out_data", out_data, 0);
        check("flush_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        step();
        check("flush_no_aa", {31'd0, out_valid}, 0);

        // Single-entry mode: in_ready follows out_ready while holding
        in_valid0 = 1'b1; in_data0 = 32'h10; out_ready0 = 1'b1;
        step();
        in_data0 = 32'h11; out_ready0 = 1'b0;
        #1;
        check("s0_ready_low", {31'd0, in_ready0}, 0);
        step();
        check("s0_stall_data", out_data0, 32'h10);
        out_ready0 = 1'b1;
        #1;
        check("s0_ready_high", {31'd0, in_ready0}, 1);
        step();
        check("s0_next_data", out_data0, 32'h11);
        in_data0 = 32'h12;
        step();
        in_valid0 = 1'b0;
        check("s0_last_data", out_data0, 32'h12);
        check("s0_count", {30'd0, count0}, 1);
        step();
        check("s0_empty", {30'd0, count0}, 0);
        in_valid0 = 1'b1; in_data0 = 32'h55; out_ready0 = 1'b0;
        step();
        in_valid0 = 1'b0; flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        check("s0_flush_valid", {31'd0, out_valid0}, 0);
        check("s0_flush_keep_data", out_data0, 32'h55);

        // Asynchronous reset in the middle of a cycle while full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
        step();
        in_data = 32'h44;
        step();
        in_valid = 1'b0;
        check("pre_rst_count", {30'd0, count}, 2);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_count", {30'd0, count}, 0);
        check("arst_out_data", out_data, 0);
        check("arst_in_ready", {31'd0, in_ready}, 1);
        step();
        rst = 1'b0;

        // Random traffic on both instances against the scoreboards
        exp_q.delete();
        exp0_q.delete();
        sb_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            in_valid0  = ($urandom_range(0, 3) != 0);
            in_data0   = $urandom;
            out_ready0 = ($urandom_range(0, 3) != 0);
            flush0     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; in_valid0 = 1'b0; flush0 = 1'b0;
        step();
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
